// File: rtl/pll_reset_sequencer.sv
// PLL supervisor: drives pll_areset, qualifies pll_locked and releases sys_rst after stable lock.
// Define PLL_SEQ_DEGLITCH_EN to require DEGLITCH_CYCLES of persistent lock loss while in RUN.
module pll_reset_sequencer #(
  parameter int unsigned AR_CYCLES       = 16,
  parameter int unsigned LOCK_TIMEOUT    = 65536,
  parameter int unsigned SETTLE_CYCLES   = 1024,
  parameter int unsigned MAX_RETRY       = 3,
  parameter int unsigned DEGLITCH_CYCLES = 8
) (
  input  logic       in_clk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       soft_reset_req,
  output logic       pll_areset,
  output logic       sys_rst,
  output logic       ready,
  output logic       fault,
  output logic [7:0] lock_lost_count
);

  localparam int unsigned MAX_AR_TO = (AR_CYCLES > LOCK_TIMEOUT) ? AR_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned MAX_CNT   = (MAX_AR_TO > SETTLE_CYCLES) ? MAX_AR_TO : SETTLE_CYCLES;
  localparam int unsigned CNT_W     = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] AR_LAST     = CNT_W'(AR_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [3:0]       RETRY_MAX   = 4'(MAX_RETRY);

  if (AR_CYCLES < 1 || LOCK_TIMEOUT < 2 || SETTLE_CYCLES < 1 ||
      MAX_RETRY < 1 || MAX_RETRY > 15 || DEGLITCH_CYCLES < 1) begin : g_bad_params
    $error("pll_reset_sequencer: parameter out of range");
  end

  typedef enum logic [2:0] {
    ST_PLL_RESET,
    ST_WAIT_LOCK,
    ST_SETTLE,
    ST_RUN,
    ST_FAULT
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       retry_cnt, retry_nxt;
  logic [7:0]       lost_nxt;
  logic             areset_nxt, sys_rst_nxt, ready_nxt, fault_nxt;
  logic             lock_loss;
  logic             sync_p0, sync_p1;
  logic             locked_s;

`ifdef PLL_SEQ_DEGLITCH_EN
  localparam int unsigned      DG_W    = (DEGLITCH_CYCLES > 1) ? $clog2(DEGLITCH_CYCLES) : 1;
  localparam logic [DG_W-1:0]  DG_LAST = DG_W'(DEGLITCH_CYCLES - 1);
  logic [DG_W-1:0] dg_cnt, dg_nxt;
`endif

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Stage p0/p1: bring the asynchronous lock flag into the in_clk domain
  always_ff @(posedge in_clk) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= pll_locked;
      sync_p1 <= sync_p0;
    end
  end

  assign locked_s = sync_p1;

  always_comb begin
    state_nxt = state;
    retry_nxt = retry_cnt;
    lost_nxt  = lock_lost_count;
    lock_loss = 1'b0;
    cnt_nxt   = '0;
`ifdef PLL_SEQ_DEGLITCH_EN
    dg_nxt    = '0;
`endif

    case (state)
      ST_PLL_RESET: begin
        if (cnt == AR_LAST) state_nxt = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (locked_s) begin
          state_nxt = ST_SETTLE;
        end else if (cnt == TO_LAST) begin
          retry_nxt = retry_cnt + 4'd1;
          state_nxt = (retry_nxt == RETRY_MAX) ? ST_FAULT : ST_PLL_RESET;
        end
      end
      ST_SETTLE: begin
        if (!locked_s) begin
          state_nxt = ST_WAIT_LOCK;
        end else if (cnt == SETTLE_LAST) begin
          state_nxt = ST_RUN;
          retry_nxt = '0;
        end
      end
      ST_RUN: begin
`ifdef PLL_SEQ_DEGLITCH_EN
        if (!locked_s) begin
          if (dg_cnt == DG_LAST) lock_loss = 1'b1;
          else                   dg_nxt    = dg_cnt + DG_W'(1);
        end
`else
        lock_loss = !locked_s;
`endif
        // Lock loss wins over a coincident soft request so it is always counted
        if (lock_loss) begin
          state_nxt = ST_PLL_RESET;
          lost_nxt  = sat_inc8(lock_lost_count);
        end else if (soft_reset_req) begin
          state_nxt = ST_PLL_RESET;
        end
      end
      ST_FAULT: begin
        state_nxt = ST_FAULT;
      end
      default: begin
        state_nxt = ST_PLL_RESET;
      end
    endcase

    if (state_nxt == state && state != ST_RUN && state != ST_FAULT)
      cnt_nxt = cnt + CNT_W'(1);

    areset_nxt  = (state_nxt == ST_PLL_RESET) || (state_nxt == ST_FAULT);
    sys_rst_nxt = (state_nxt != ST_RUN);
    ready_nxt   = (state_nxt == ST_RUN);
    fault_nxt   = (state_nxt == ST_FAULT);
  end

  // Stage p2: state, counters and outputs all update on the same edge
  always_ff @(posedge in_clk) begin
    if (rst) begin
      state           <= ST_PLL_RESET;
      cnt             <= '0;
      retry_cnt       <= '0;
      lock_lost_count <= '0;
      pll_areset      <= 1'b1;
      sys_rst         <= 1'b1;
      ready           <= 1'b0;
      fault           <= 1'b0;
`ifdef PLL_SEQ_DEGLITCH_EN
      dg_cnt          <= '0;
`endif
    end else begin
      state           <= state_nxt;
      cnt             <= cnt_nxt;
      retry_cnt       <= retry_nxt;
      lock_lost_count <= lost_nxt;
      pll_areset      <= areset_nxt;
      sys_rst         <= sys_rst_nxt;
      ready           <= ready_nxt;
      fault           <= fault_nxt;
`ifdef PLL_SEQ_DEGLITCH_EN
      dg_cnt          <= dg_nxt;
`endif
    end
  end

endmodule
